// File: rtl/ram_block_copy_pkg.sv
// ============================================================================
// Module   : ram_copy_pkg
// Purpose  : Shared state encoding and direction constants for the RAM
//            block-copy engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ram_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_block_copy_if.sv
// ============================================================================
// Module   : ram_block_copy_if
// Purpose  : Control handshake plus RAM read/write port bundle of the copy
//            engine; slave is the engine view, master the system view.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_block_copy_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic              ready;
    logic              done;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] ram_raddr_0;
    logic [DATA_W-1:0] ram_rdata_0;
    logic [ADDR_W-1:0] ram_waddr_0;
    logic              ram_wen_0;
    logic [DATA_W-1:0] ram_wdata_0;

    modport slave (
        input  start, src_base, dst_base, len, ram_rdata_0,
        output ready, done, ram_raddr_0, ram_waddr_0, ram_wen_0, ram_wdata_0
    );

    modport master (
        output start, src_base, dst_base, len, ram_rdata_0,
        input  ready, done, ram_raddr_0, ram_waddr_0, ram_wen_0, ram_wdata_0
    );
endinterface

`default_nettype wire

// File: rtl/ram_block_copy_lat_pipe.sv
// ============================================================================
// Module   : ram_lat_pipe
// Purpose  : RD_LAT-deep shift register carrying {valid, dst_addr} so each
//            write lines up with the RAM read data it belongs to.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_valid,
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic                   o_valid,
    output logic [ADDR_W-1:0]      o_addr,
    output logic                   o_busy
);

    logic [RD_LAT-1:0] r_valid;
    logic [ADDR_W-1:0] r_addr [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_addr  = r_addr[RD_LAT-1];

    // Busy means a write is still pending beyond the one at the tail this cycle.
    generate
        if (RD_LAT == 1) begin : g_single
            assign o_busy = 1'b0;
        end else begin : g_multi
            assign o_busy = |r_valid[RD_LAT-2:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ram_block_copy.sv
// ============================================================================
// Module   : ram_block_copy
// Purpose  : Copies len words from src_base to dst_base through one RAM read
//            and one write port, choosing direction so overlaps copy safely.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_block_copy
    import ram_copy_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ram_block_copy_if.slave bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_src_addr;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_dir;

    logic              w_ready;
    logic              w_done;
    logic              w_issue;
    logic              w_accept;
    logic              w_pipe_busy;
    logic              w_pipe_valid;
    logic [ADDR_W-1:0] w_pipe_addr;
    logic [DATA_W-1:0] w_wdata;

    logic [ADDR_W:0]   w_src_ext;
    logic [ADDR_W:0]   w_dst_ext;
    logic [ADDR_W:0]   w_src_end;
    logic              w_desc;
    logic [ADDR_W-1:0] w_len_m1;
    logic [ADDR_W-1:0] w_src_first;
    logic [ADDR_W-1:0] w_dst_first;

    // Overlap test is done one bit wider so src_base+len cannot wrap.
    assign w_src_ext   = {1'b0, bus.src_base};
    assign w_dst_ext   = {1'b0, bus.dst_base};
    assign w_src_end   = w_src_ext + (ADDR_W+1)'(bus.len);
    assign w_desc      = (w_dst_ext > w_src_ext) && (w_dst_ext < w_src_end);
    assign w_len_m1    = ADDR_W'(bus.len) - ADDR_W'(1);
    assign w_src_first = w_desc ? bus.src_base + w_len_m1 : bus.src_base;
    assign w_dst_first = w_desc ? bus.dst_base + w_len_m1 : bus.dst_base;

    assign w_accept = bus.start && w_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_next_state = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_remaining == LEN_W'(1)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_pipe_busy) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        w_done  = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            IDLE:    w_ready = 1'b1;
            RUN:     w_issue = 1'b1;
            DONE: begin
                w_ready = 1'b1;
                w_done  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address counters, issue counter and direction flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_addr  <= '0;
            r_dst_addr  <= '0;
            r_remaining <= '0;
            r_dir       <= DIR_ASC;
        end else if (w_accept) begin
            r_src_addr  <= w_src_first;
            r_dst_addr  <= w_dst_first;
            r_remaining <= bus.len;
            r_dir       <= w_desc ? DIR_DESC : DIR_ASC;
        end else if (w_issue) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_dir == DIR_DESC) begin
                r_src_addr <= r_src_addr - ADDR_W'(1);
                r_dst_addr <= r_dst_addr - ADDR_W'(1);
            end else begin
                r_src_addr <= r_src_addr + ADDR_W'(1);
                r_dst_addr <= r_dst_addr + ADDR_W'(1);
            end
        end
    end

    ram_lat_pipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_addr  (r_dst_addr),
        .o_valid (w_pipe_valid),
        .o_addr  (w_pipe_addr),
        .o_busy  (w_pipe_busy)
    );

    // Write data is the RAM read data of the same cycle, no extra register.
    assign w_wdata         = bus.ram_rdata_0;
    assign bus.ram_wdata_0 = w_wdata;
    assign bus.ram_raddr_0 = r_src_addr;
    assign bus.ram_waddr_0 = w_pipe_addr;
    assign bus.ram_wen_0   = w_pipe_valid;
    assign bus.ready       = w_ready;
    assign bus.done        = w_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_block_copy.sv
// ============================================================================
// Module   : tb_ram_block_copy
// Purpose  : Self-checking bench with RAM models at RD_LAT=1 and RD_LAT=3;
//            expected writes are queued per copy and popped on each wen.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_block_copy;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        use_b;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a;
    logic [31:0] rd_b1, rd_b2, rd_b3;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    ram_block_copy_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) bus_a ();
    ram_block_copy_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) bus_b ();

    ram_block_copy #(.DATA_W(32), .ADDR_W(32), .LEN_W(16), .RD_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ram_block_copy #(.DATA_W(32), .ADDR_W(32), .LEN_W(16), .RD_LAT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_a.start       = start & ~use_b;
    assign bus_a.src_base    = src;
    assign bus_a.dst_base    = dst;
    assign bus_a.len         = len;
    assign bus_a.ram_rdata_0 = rd_a;
    assign bus_b.start       = start & use_b;
    assign bus_b.src_base    = src;
    assign bus_b.dst_base    = dst;
    assign bus_b.len         = len;
    assign bus_b.ram_rdata_0 = rd_b3;

    // RAM models: synchronous read with 1 or 3 cycles of latency
    always @(posedge clk) begin
        rd_a <= mem_a[bus_a.ram_raddr_0[7:0]];
        if (dbg_we) mem_a[dbg_addr] <= dbg_data;
        else if (bus_a.ram_wen_0) mem_a[bus_a.ram_waddr_0[7:0]] <= bus_a.ram_wdata_0;
    end

    always @(posedge clk) begin
        rd_b1 <= mem_b[bus_b.ram_raddr_0[7:0]];
        rd_b2 <= rd_b1;
        rd_b3 <= rd_b2;
        if (dbg_we) mem_b[dbg_addr] <= dbg_data;
        else if (bus_b.ram_wen_0) mem_b[bus_b.ram_waddr_0[7:0]] <= bus_b.ram_wdata_0;
    end

    logic        cur_wen, cur_ready, cur_done;
    logic [31:0] cur_waddr, cur_wdata;
    assign cur_wen   = use_b ? bus_b.ram_wen_0   : bus_a.ram_wen_0;
    assign cur_ready = use_b ? bus_b.ready       : bus_a.ready;
    assign cur_done  = use_b ? bus_b.done        : bus_a.done;
    assign cur_waddr = use_b ? bus_b.ram_waddr_0 : bus_a.ram_waddr_0;
    assign cur_wdata = use_b ? bus_b.ram_wdata_0 : bus_a.ram_wdata_0;

    function automatic logic [31:0] mem_rd(input logic b, input logic [31:0] a);
        return b ? mem_b[a[7:0]] : mem_a[a[7:0]];
    endfunction

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        dbg_we   = 1'b1;
        dbg_addr = a;
        dbg_data = d;
        @(posedge clk);
        #1;
        dbg_we = 1'b0;
    endtask

    // Run one copy, check each write against the queue, then check memory.
    task automatic run_copy(input logic b, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input bit hold);
        int          lat;
        int          last;
        logic [32:0] s_end;
        bit          desc;
        logic [31:0] snap [256];
        logic [31:0] ko, sidx, a;
        exp_t        e;
        lat = b ? 3 : 1;
        for (int i = 0; i < 256; i++) snap[i] = mem_rd(b, 32'(i));
        s_end = {1'b0, s} + 33'(n);
        desc  = ({1'b0, d} > {1'b0, s}) && ({1'b0, d} < s_end);
        sb.delete();
        for (int i = 0; i < int'(n); i++) begin
            ko     = desc ? 32'(int'(n) - 1 - i) : 32'(i);
            sidx   = s + ko;
            e.addr = d + ko;
            e.data = snap[sidx[7:0]];
            e.cyc  = 32'(1 + lat + i);
            sb.push_back(e);
        end
        last = (n == 0) ? 1 : int'(n) + lat + 1;
        @(negedge clk);
        use_b = b; src = s; dst = d; len = n; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (hold && cyc == int'(n) + lat) start = 1'b0;
            if (cyc == 1 && n != 0) begin
                n_checks++;
                if (cur_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", cur_ready);
                else n_pass++;
            end
            if (cur_wen === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_wen cyc %0d: got wen=1 waddr=%0h want no write", cyc, cur_waddr);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (cur_waddr !== e.addr) $display("FAIL waddr cyc %0d: got %0h want %0h", cyc, cur_waddr, e.addr);
                    else n_pass++;
                    n_checks++;
                    if (cur_wdata !== e.data) $display("FAIL wdata cyc %0d: got %0h want %0h", cyc, cur_wdata, e.data);
                    else n_pass++;
                    n_checks++;
                    if (32'(cyc) !== e.cyc) $display("FAIL wen_cycle: got %0d want %0d", cyc, e.cyc);
                    else n_pass++;
                end
            end
            if (cyc == last - 1 && n != 0) begin
                n_checks++;
                if (cur_done !== 1'b0) $display("FAIL done_early cyc %0d: got %b want 0", cyc, cur_done);
                else n_pass++;
            end
            if (cyc == last) begin
                n_checks++;
                if ({cur_done, cur_ready} !== 2'b11)
                    $display("FAIL done_ready cyc %0d: got done=%b ready=%b want 1/1", cyc, cur_done, cur_ready);
                else n_pass++;
            end
            if (cyc < last) begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL missing_wen: got %0d writes outstanding want 0", sb.size());
        else n_pass++;
        for (int i = 0; i < int'(n); i++) begin
            sidx = s + 32'(i);
            a    = d + 32'(i);
            n_checks++;
            if (mem_rd(b, a) !== snap[sidx[7:0]])
                $display("FAIL mem[%0d]: got %0h want %0h", a, mem_rd(b, a), snap[sidx[7:0]]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; use_b = 1'b0; dbg_we = 1'b0;
        src = '0; dst = '0; len = '0; dbg_addr = '0; dbg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus_a.ready); else n_pass++;
        n_checks++;
        if (bus_a.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus_a.done); else n_pass++;
        n_checks++;
        if (bus_a.ram_wen_0 !== 1'b0) $display("FAIL rst_wen: got %b want 0", bus_a.ram_wen_0); else n_pass++;
        n_checks++;
        if (bus_a.ram_raddr_0 !== 32'h0) $display("FAIL rst_raddr: got %0h want 0", bus_a.ram_raddr_0); else n_pass++;
        n_checks++;
        if (bus_a.ram_waddr_0 !== 32'h0) $display("FAIL rst_waddr: got %0h want 0", bus_a.ram_waddr_0); else n_pass++;
        n_checks++;
        if ({bus_b.ready, bus_b.done, bus_b.ram_wen_0} !== 3'b100)
            $display("FAIL rst_b: got %b want 100", {bus_b.ready, bus_b.done, bus_b.ram_wen_0});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        preload(8'd10, 32'd15);
        preload(8'd12, 32'd0);
        run_copy(1'b0, 32'd10, 32'd12, 16'd1, 1'b0);
    endtask

    task automatic test_block();
        for (int i = 0; i < 8; i++) preload(8'(i), 32'(i + 1));
        run_copy(1'b0, 32'd0, 32'd100, 16'd8, 1'b0);
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 10; i++) preload(8'(i), (i < 8) ? 32'(i + 1) : 32'h0);
        run_copy(1'b0, 32'd0, 32'd2, 16'd8, 1'b0);
        run_copy(1'b0, 32'd4, 32'd2, 16'd6, 1'b0);
    endtask

    task automatic test_len_zero_and_hold();
        run_copy(1'b0, 32'd5, 32'd6, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) preload(8'(30 + i), 32'h100 + 32'(i));
        run_copy(1'b0, 32'd30, 32'd70, 16'd4, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus_a.done, bus_a.ram_wen_0} !== 2'b10)
            $display("FAIL no_restart: got done=%b wen=%b want 1/0", bus_a.done, bus_a.ram_wen_0);
        else n_pass++;
    endtask

    task automatic test_lat3();
        for (int i = 0; i < 4; i++) preload(8'(20 + i), 32'hA0 + 32'(i));
        run_copy(1'b1, 32'd20, 32'd40, 16'd4, 1'b0);
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int i = 0; i < 8; i++) preload(8'(i), 32'h50 + 32'(i));
        @(negedge clk);
        use_b = 1'b0; src = 32'd0; dst = 32'd50; len = 16'd8; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus_a.ram_wen_0, bus_a.ready, bus_a.done} !== 3'b010)
            $display("FAIL mid_rst: got wen/ready/done=%b want 010", {bus_a.ram_wen_0, bus_a.ready, bus_a.done});
        else n_pass++;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.ram_wen_0 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL post_rst_wen: got %0d write cycles want 0", bad);
        else n_pass++;
        run_copy(1'b0, 32'd0, 32'd60, 16'd8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_block();
        test_overlap();
        test_len_zero_and_hold();
        test_lat3();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
